gpnae_frame_feeder: RTL and testbench
=====================================

Name: gpnae_frame_feeder

Overview:
- Upstream stage of the GPNAE neuron datapath.
- Accepts one operation descriptor (control word) plus a valid/ready stream of DATA_WIDTH operand beats.
- Writes the beats into the neuron's input FIFO while honouring its full flag, counts terms, then raises last with a stable term count and control word.
- Holds off the next frame until the neuron reports done, or until a watchdog expires.

Parameters:
DATA_WIDTH, 32, operand/beat width
ADDR_LINES, 5, term-counter width; max terms per frame MAX_TERMS = 2^ADDR_LINES-1 (31)
CONTROL_WIDTH, 2, operation code width (01 SeLU, 10 sigmoid, 11 tanh, 00 invalid)
TIMEOUT_CYCLES, 1024, WAIT_DONE watchdog limit in clk_i cycles

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  asynchronous, active-high reset
cfg_op_i  in  CONTROL_WIDTH  requested operation code
cfg_valid_i  in  1  descriptor valid
cfg_ready_o  out  1  descriptor accepted when cfg_valid_i & cfg_ready_o
s_data_i  in  DATA_WIDTH  operand beat
s_valid_i  in  1  beat valid
s_last_i  in  1  final beat of frame
s_ready_o  out  1  beat accepted when s_valid_i & s_ready_o
full_i  in  1  neuron FIFO full
done_i  in  1  neuron result-done pulse
signal_o  out  DATA_WIDTH  FIFO write data
wr_en_o  out  1  FIFO write strobe
last_o  out  1  end-of-frame pulse to neuron
terms_o  out  ADDR_LINES  accepted-term count of current frame
control_word_o  out  CONTROL_WIDTH  latched operation code
busy_o  out  1  high in any state other than IDLE
frame_cnt_o  out  16  completed frames, wraps at 2^16
trunc_err_o  out  1  sticky: frame truncated at MAX_TERMS
op_err_o  out  1  sticky: descriptor with op 00 rejected
timeout_err_o  out  1  sticky: watchdog expired

Behaviour:
- Interface (already decided): one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts immediately; an in-flight beat is not acknowledged and no partial last_o is issued.
- States: IDLE, LOAD, LAST, WAIT_DONE.
- IDLE:
  - cfg_ready_o is registered 1, rising the first cycle after reset release and on every re-entry to IDLE.
  - On handshake with cfg_op_i==00: set op_err_o, stay in IDLE.
  - Otherwise: latch control_word_o, clear terms_o, go to LOAD.
  - cfg_ready_o=0 in all other states; descriptors presented there are ignored.
- LOAD:
  - s_ready_o = ~full_i & (terms_o < MAX_TERMS), combinational.
  - Beat handshake is zero-latency: signal_o = s_data_i, wr_en_o = s_valid_i & s_ready_o.
  - terms_o increments on each accepted beat.
  - Accepted beat with s_last_i=1: go to LAST.
  - Accepted beat that makes terms_o==MAX_TERMS with s_last_i=0: set trunc_err_o, go to LAST. The stream's remaining beats are left to the next frame.
  - full_i high: s_ready_o=0 and no write that cycle; resume when full_i falls.
  - s_ready_o=0 outside LOAD.
- LAST: last_o=1 for exactly one cycle, then WAIT_DONE.
- Stability: terms_o and control_word_o hold stable from LAST until the return to IDLE.
- WAIT_DONE:
  - Watchdog counts cycles from entry.
  - done_i: increment frame_cnt_o, go to IDLE.
  - Watchdog reaches TIMEOUT_CYCLES without done_i: set timeout_err_o, go to IDLE.
  - done_i in the same cycle the watchdog expires: done wins, no error.
- done_i outside WAIT_DONE is ignored.
- Sticky error flags clear only on reset.
- Minimum frame is one beat. Latency from the accepted last beat to last_o is 1 cycle.

Test Plan:
- Reset release, cfg op=01, 4 beats (last on 4th), no backpressure -> 4 wr_en_o pulses carrying the data, last_o 1 cycle after 4th beat, terms_o=4, control_word_o=01; done_i 20 cycles later -> frame_cnt_o=1, cfg_ready_o=1.
- full_i high 3 cycles during beat 2 of a 3-beat frame -> s_ready_o=0 and no wr_en_o for those 3 cycles, no data loss or duplication, terms_o=3.
- 40-beat stream with no s_last_i -> 31 writes, trunc_err_o=1, last_o asserted, terms_o=31.
- cfg op=00 -> op_err_o=1, busy_o stays 0; subsequent op=10 descriptor accepted normally.
- Frame completed but done_i never arrives -> timeout_err_o=1 after 1024 cycles in WAIT_DONE, return to IDLE; separate case with done_i on cycle 1024 -> no error, frame_cnt_o increments.
- rst_i pulsed asynchronously mid-LOAD after 2 beats -> all outputs 0 immediately, no last_o, next frame starts with terms_o=0.

Source files
------------

// File: rtl/gpnae_frame_feeder.sv
// Frame feeder for the GPNAE neuron: takes an op descriptor and a beat stream, fills the
// neuron input FIFO, marks end-of-frame, then waits for the neuron (with a watchdog).
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | ready for a descriptor; op 00 is flagged and rejected
// S_LOAD      | forwarding beats into the neuron FIFO, counting terms
// S_LAST      | one-cycle end-of-frame pulse, terms/op frozen
// S_WAIT_DONE | waiting for neuron done, watchdog running
module gpnae_frame_feeder #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_LINES     = 5,
    parameter int unsigned CONTROL_WIDTH  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [CONTROL_WIDTH-1:0] cfg_op_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [DATA_WIDTH-1:0]    s_data_i,
    input  logic                     s_valid_i,
    input  logic                     s_last_i,
    output logic                     s_ready_o,
    input  logic                     full_i,
    input  logic                     done_i,
    output logic [DATA_WIDTH-1:0]    signal_o,
    output logic                     wr_en_o,
    output logic                     last_o,
    output logic [ADDR_LINES-1:0]    terms_o,
    output logic [CONTROL_WIDTH-1:0] control_word_o,
    output logic                     busy_o,
    output logic [15:0]              frame_cnt_o,
    output logic                     trunc_err_o,
    output logic                     op_err_o,
    output logic                     timeout_err_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_LINES-1:0] MAX_TERMS    = '1;
    localparam logic [ADDR_LINES-1:0] MAX_TERMS_M1 = MAX_TERMS - ADDR_LINES'(1);
    localparam logic [WD_W-1:0]       WD_LOAD      = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_LAST      = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_cfg_ready;
    logic [ADDR_LINES-1:0]    r_terms;
    logic [CONTROL_WIDTH-1:0] r_control_word;
    logic [15:0]              r_frame_cnt;
    logic                     r_trunc_err;
    logic                     r_op_err;
    logic                     r_timeout_err;
    logic [WD_W-1:0]          r_wd_cnt;

    logic w_cfg_fire;
    logic w_op_valid;
    logic w_s_ready;
    logic w_beat;
    logic w_term_max;
    logic w_wd_tc;

    assign w_cfg_fire = cfg_valid_i & r_cfg_ready & (r_state == S_IDLE);
    assign w_op_valid = (cfg_op_i != '0);
    assign w_beat     = s_valid_i & w_s_ready;
    // The accepted beat that brings the count to MAX_TERMS ends the frame.
    assign w_term_max = (r_terms == MAX_TERMS_M1);
    assign w_wd_tc    = (r_wd_cnt == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        signal_o    = '0;
        wr_en_o     = 1'b0;
        last_o      = 1'b0;
        busy_o      = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (w_cfg_fire && w_op_valid) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_s_ready = ~full_i & (r_terms < MAX_TERMS);
                signal_o  = s_data_i;
                wr_en_o   = s_valid_i & w_s_ready;
                if (s_valid_i && w_s_ready && (s_last_i || w_term_max)) begin
                    w_state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                last_o      = 1'b1;
                w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_i || w_wd_tc) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cfg_ready    <= 1'b0;
            r_terms        <= '0;
            r_control_word <= '0;
            r_frame_cnt    <= '0;
            r_trunc_err    <= 1'b0;
            r_op_err       <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_wd_cnt       <= '0;
        end else begin
            r_cfg_ready <= (w_state_nxt == S_IDLE);

            if (w_cfg_fire) begin
                if (w_op_valid) begin
                    r_control_word <= cfg_op_i;
                    r_terms        <= '0;
                end else begin
                    r_op_err <= 1'b1;
                end
            end

            if (w_beat) begin
                r_terms <= r_terms + ADDR_LINES'(1);
                if (w_term_max && !s_last_i) begin
                    r_trunc_err <= 1'b1;
                end
            end

            // Watchdog is armed in LAST so WAIT_DONE sees exactly TIMEOUT_CYCLES cycles.
            if (r_state == S_LAST) begin
                r_wd_cnt <= WD_LOAD;
            end else if (r_state == S_WAIT_DONE && !w_wd_tc) begin
                r_wd_cnt <= r_wd_cnt - WD_W'(1);
            end

            if (r_state == S_WAIT_DONE) begin
                if (done_i) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else if (w_wd_tc) begin
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

    assign cfg_ready_o    = r_cfg_ready;
    assign s_ready_o      = w_s_ready;
    assign terms_o        = r_terms;
    assign control_word_o = r_control_word;
    assign frame_cnt_o    = r_frame_cnt;
    assign trunc_err_o    = r_trunc_err;
    assign op_err_o       = r_op_err;
    assign timeout_err_o  = r_timeout_err;

endmodule

// File: tb/tb_gpnae_frame_feeder.sv
// Bench for gpnae_frame_feeder: directed scenarios plus randomized frames, checked every
// cycle against a phase-level model of the feeder and a source-side beat queue.
module tb_gpnae_frame_feeder;

    localparam int DW   = 32;
    localparam int AL   = 5;
    localparam int CW   = 2;
    localparam int TO   = 1024;
    localparam int MAXT = 31;

    localparam int MI = 0, ML = 1, MLAST = 2, MW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [CW-1:0] cfg_op_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [DW-1:0] s_data_i;
    logic          s_valid_i;
    logic          s_last_i;
    logic          s_ready_o;
    logic          full_i;
    logic          done_i;
    logic [DW-1:0] signal_o;
    logic          wr_en_o;
    logic          last_o;
    logic [AL-1:0] terms_o;
    logic [CW-1:0] control_word_o;
    logic          busy_o;
    logic [15:0]   frame_cnt_o;
    logic          trunc_err_o;
    logic          op_err_o;
    logic          timeout_err_o;

    always #5 clk_i = ~clk_i;

    gpnae_frame_feeder #(
        .DATA_WIDTH(DW), .ADDR_LINES(AL), .CONTROL_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_op_i(cfg_op_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
        .full_i(full_i), .done_i(done_i),
        .signal_o(signal_o), .wr_en_o(wr_en_o), .last_o(last_o), .terms_o(terms_o),
        .control_word_o(control_word_o), .busy_o(busy_o), .frame_cnt_o(frame_cnt_o),
        .trunc_err_o(trunc_err_o), .op_err_o(op_err_o), .timeout_err_o(timeout_err_o)
    );

    int errors = 0;
    int checks = 0;

    // model of the feeder: phase of the frame plus the architectural counters/flags
    int m_mode, m_terms, m_cw, m_frames, m_age;
    bit m_trunc, m_op, m_to, m_cfg_rdy, m_acc;

    logic [32:0] src_q[$];  // {last, data} beats waiting at the source

    int valid_pct = 100, full_pct = 0, full_force = -1;
    bit noise = 0;
    bit cfg_req = 0, done_req = 0;
    logic [1:0] cfg_req_op = 2'b00;

    int wr_seen = 0, last_seen = 0, last_terms = 0, last_cw = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (got no event, expected one) at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_mode = MI; m_terms = 0; m_cw = 0; m_frames = 0; m_age = 0;
        m_trunc = 0; m_op = 0; m_to = 0; m_cfg_rdy = 0; m_acc = 0;
    endtask

    function automatic bit exp_srdy();
        return (m_mode == ML) && !full_i && (m_terms < MAXT);
    endfunction

    task automatic drive_inputs();
        if (src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
            s_valid_i = 1'b1;
            s_data_i  = src_q[0][31:0];
            s_last_i  = src_q[0][32];
        end else begin
            s_valid_i = 1'b0;
            s_data_i  = $urandom;
            s_last_i  = 1'($urandom_range(1));
        end
        full_i = (full_force >= 0) ? full_force[0] : ($urandom_range(99) < full_pct);
        if (m_mode == MW)  done_i = done_req;
        else               done_i = noise ? ($urandom_range(7) == 0) : 1'b0;
        if (m_mode == MI) begin
            cfg_valid_i = cfg_req;
            cfg_op_i    = cfg_req_op;
        end else begin
            cfg_valid_i = noise ? ($urandom_range(3) == 0) : 1'b0;
            cfg_op_i    = 2'($urandom_range(3));
        end
    endtask

    task automatic compare();
        bit wr;
        wr = exp_srdy() && s_valid_i;
        chk("cfg_ready", 32'(cfg_ready_o), 32'(m_cfg_rdy));
        chk("s_ready", 32'(s_ready_o), 32'(exp_srdy()));
        chk("wr_en", 32'(wr_en_o), 32'(wr));
        if (wr) chk("signal", signal_o, src_q[0][31:0]);
        chk("last", 32'(last_o), 32'(m_mode == MLAST));
        chk("busy", 32'(busy_o), 32'(m_mode != MI));
        chk("terms", 32'(terms_o), m_terms);
        chk("control_word", 32'(control_word_o), m_cw);
        chk("frame_cnt", 32'(frame_cnt_o), m_frames);
        chk("trunc_err", 32'(trunc_err_o), 32'(m_trunc));
        chk("op_err", 32'(op_err_o), 32'(m_op));
        chk("timeout_err", 32'(timeout_err_o), 32'(m_to));
        if (wr_en_o) wr_seen++;
        if (last_o) begin
            last_seen++;
            last_terms = int'(terms_o);
            last_cw    = int'(control_word_o);
        end
    endtask

    task automatic model_step();
        bit beat;
        beat  = exp_srdy() && s_valid_i;
        m_acc = 0;
        case (m_mode)
            MI: if (cfg_valid_i && m_cfg_rdy) begin
                m_acc = 1;
                if (cfg_op_i == 2'b00) m_op = 1;
                else begin
                    m_cw = int'(cfg_op_i); m_terms = 0; m_mode = ML;
                end
            end
            ML: if (beat) begin
                void'(src_q.pop_front());
                m_terms++;
                if (s_last_i) m_mode = MLAST;
                else if (m_terms == MAXT) begin
                    m_trunc = 1; m_mode = MLAST;
                end
            end
            MLAST: begin
                m_mode = MW; m_age = 0;
            end
            default: begin
                m_age++;
                if (done_i) begin
                    m_frames = (m_frames + 1) % 65536; m_mode = MI;
                end else if (m_age == TO) begin
                    m_to = 1; m_mode = MI;
                end
            end
        endcase
        m_cfg_rdy = (m_mode == MI);
    endtask

    task automatic cycle();
        drive_inputs();
        #1;
        compare();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic push_beats(input int n, input bit with_last);
        for (int i = 0; i < n; i++)
            src_q.push_back({with_last && (i == n - 1), 32'($urandom)});
    endtask

    task automatic start_frame(input logic [1:0] op);
        bit got = 0;
        cfg_req = 1; cfg_req_op = op;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle();
            got = m_acc;
        end
        if (!got) bound_fail("cfg_accept");
        cfg_req = 0;
    endtask

    task automatic wait_mode(input int mode, input int budget, input string name);
        int n = 0;
        while (m_mode != mode && n < budget) begin
            cycle();
            n++;
        end
        if (m_mode != mode) bound_fail(name);
    endtask

    task automatic finish_frame(input int delay);
        wait_mode(MW, 3000, "reach_wait_done");
        if (delay >= TO) begin
            wait_mode(MI, TO + 10, "timeout_return");
        end else begin
            repeat (delay) cycle();
            done_req = 1;
            cycle();
            done_req = 0;
        end
    endtask

    task automatic run_frame(input logic [1:0] op, input int delay);
        start_frame(op);
        if (op != 2'b00) begin
            wait_mode(MLAST, 3000, "reach_last");
            finish_frame(delay);
        end
    endtask

    task automatic async_reset_check();
        drive_inputs();
        #1;
        rst_i = 1'b1;
        #1;
        chk("rst_cfg_ready", 32'(cfg_ready_o), 0);
        chk("rst_s_ready", 32'(s_ready_o), 0);
        chk("rst_wr_en", 32'(wr_en_o), 0);
        chk("rst_signal", signal_o, 0);
        chk("rst_last", 32'(last_o), 0);
        chk("rst_terms", 32'(terms_o), 0);
        chk("rst_control_word", 32'(control_word_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_frame_cnt", 32'(frame_cnt_o), 0);
        chk("rst_errs", {29'd0, trunc_err_o, op_err_o, timeout_err_o}, 0);
        model_reset();
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    int w0, l0, f0;

    initial begin
        rst_i = 1'b1; cfg_valid_i = 0; cfg_op_i = 0; s_data_i = 0; s_valid_i = 0;
        s_last_i = 0; full_i = 0; done_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("init_cfg_ready", 32'(cfg_ready_o), 0);
        chk("init_busy", 32'(busy_o), 0);
        chk("init_frame_cnt", 32'(frame_cnt_o), 0);
        rst_i = 1'b0;
        cycle();
        chk("init_cfg_ready_rise", 32'(cfg_ready_o), 1);

        // 4-beat SeLU frame, no backpressure, done 20 cycles into WAIT_DONE
        w0 = wr_seen;
        push_beats(4, 1);
        run_frame(2'b01, 20);
        chk("t1_writes", wr_seen - w0, 4);
        chk("t1_last_terms", last_terms, 4);
        chk("t1_last_cw", last_cw, 1);
        chk("t1_frame_cnt", 32'(frame_cnt_o), 1);
        chk("t1_cfg_ready", 32'(cfg_ready_o), 1);

        // FIFO full for 3 cycles during beat 2
        w0 = wr_seen;
        push_beats(3, 1);
        full_force = 0;
        start_frame(2'b11);
        for (int n = 0; n < 20 && wr_seen - w0 < 1; n++) cycle();
        full_force = 1;
        l0 = wr_seen;
        repeat (3) cycle();
        chk("t2_no_write_while_full", wr_seen - l0, 0);
        full_force = 0;
        wait_mode(MLAST, 50, "t2_last");
        finish_frame(3);
        full_force = -1;
        chk("t2_writes", wr_seen - w0, 3);
        chk("t2_last_terms", last_terms, 3);

        // 40-beat stream without last -> truncated at 31
        w0 = wr_seen;
        push_beats(40, 0);
        run_frame(2'b10, 5);
        chk("t3_writes", wr_seen - w0, 31);
        chk("t3_last_terms", last_terms, 31);
        chk("t3_trunc_err", 32'(trunc_err_o), 1);
        chk("t3_leftover", src_q.size(), 9);

        // invalid op rejected, then a sigmoid frame takes the 9 leftovers + 3 more
        start_frame(2'b00);
        cycle();
        chk("t4_op_err", 32'(op_err_o), 1);
        chk("t4_busy", 32'(busy_o), 0);
        w0 = wr_seen;
        push_beats(3, 1);
        run_frame(2'b10, 1);
        chk("t4_writes", wr_seen - w0, 12);
        chk("t4_last_cw", last_cw, 2);

        // done on the final watchdog cycle wins; then a real timeout
        f0 = int'(frame_cnt_o);
        push_beats(2, 1);
        run_frame(2'b01, TO - 1);
        chk("t5_no_timeout", 32'(timeout_err_o), 0);
        chk("t5_frame_inc", 32'(frame_cnt_o), f0 + 1);
        push_beats(1, 1);
        run_frame(2'b11, TO + 100);
        chk("t5_timeout", 32'(timeout_err_o), 1);
        chk("t5_frame_same", 32'(frame_cnt_o), f0 + 1);
        chk("t5_idle", 32'(busy_o), 0);

        // async reset mid-LOAD after 2 beats
        l0 = last_seen;
        w0 = wr_seen;
        push_beats(5, 1);
        start_frame(2'b01);
        for (int n = 0; n < 20 && wr_seen - w0 < 2; n++) cycle();
        valid_pct = 100;
        async_reset_check();
        chk("t6_no_last", last_seen - l0, 0);
        chk("t6_beats_kept", src_q.size(), 3);
        start_frame(2'b11);
        chk("t6_terms_zero", 32'(terms_o), 0);
        wait_mode(MLAST, 50, "t6_last");
        finish_frame(2);
        chk("t6_last_terms", last_terms, 3);

        // randomized frames with backpressure, gaps and ignored noise on done/cfg
        noise = 1; valid_pct = 60; full_pct = 25;
        for (int k = 0; k < 30; k++) begin
            push_beats($urandom_range(40, 1), 1);
            run_frame(2'($urandom_range(3)), $urandom_range(40));
            if (m_mode == MI) repeat ($urandom_range(3)) cycle();
        end
        noise = 0;
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
